ebus_arbiter: RTL and testbench

//  Arbitrates the shared EBUS among up to NREQ drivers (APR, CON, CRA, CTL, EDP, IR, MTR, PI, SCD, SHM, VMA, ...).

---
 rtl/ebus_arbiter_pkg.sv | 37 +++
 rtl/ebus_arbiter_if.sv | 30 +++
 rtl/ebus_arbiter_rr_pick.sv | 32 +++
 rtl/ebus_arbiter.sv | 140 ++++++++++++++
 tb/tb_ebus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebus_arbiter_pkg.sv
// Shared types and helpers for the EBUS arbiter: FSM states, requester indices
// and small elaboration-time width helpers.
package ebus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DEMAND,
        ST_DONE
    } ebus_arb_state_e;

    // Requester index order matches the EBUS data mux order.
    typedef enum logic [3:0] {
        EBUS_APR = 4'd0,
        EBUS_CON = 4'd1,
        EBUS_CRA = 4'd2,
        EBUS_CTL = 4'd3,
        EBUS_EDP = 4'd4,
        EBUS_IR  = 4'd5,
        EBUS_MTR = 4'd6,
        EBUS_PI  = 4'd7,
        EBUS_SCD = 4'd8,
        EBUS_SHM = 4'd9,
        EBUS_VMA = 4'd10
    } ebus_req_e;

    localparam int EBUS_NREQ = 11;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ebus_arbiter_if.sv
// EBUS arbitration handshake: level requests and XFER in, one-hot grant,
// DEMAND and transfer status out.
interface ebus_arbiter_if
    import ebus_arbiter_pkg::*;
#(
    parameter int NREQ = EBUS_NREQ
) ();

    localparam int IDX_W = clog2_min1(NREQ);

    logic [0:NREQ-1]  req;
    logic             xfer;
    logic [0:NREQ-1]  grant;
    logic [IDX_W-1:0] grantIdx;
    logic             busy;
    logic             ebusDemand;
    logic             xferDone;
    logic             xferTimeout;

    modport master (
        input  req, xfer,
        output grant, grantIdx, busy, ebusDemand, xferDone, xferTimeout
    );

    modport slave (
        output req, xfer,
        input  grant, grantIdx, busy, ebusDemand, xferDone, xferTimeout
    );

endinterface

// File: rtl/ebus_arbiter_rr_pick.sv
// Combinational winner select: first set request at or above rr_ptr with
// wrap-around, or lowest set index when rr_mode is 0.
module ebus_arbiter_rr_pick
    import ebus_arbiter_pkg::*;
#(
    parameter  int NREQ  = EBUS_NREQ,
    localparam int IDX_W = clog2_min1(NREQ)
) (
    input  logic [0:NREQ-1]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             rr_mode,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    always_comb begin : p_pick
        int unsigned base;
        int unsigned idx;
        winner  = '0;
        any_req = 1'b0;
        base    = rr_mode ? 32'(rr_ptr) : 32'd0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (base + i) % NREQ;
            if (!any_req && req[IDX_W'(idx)]) begin
                any_req = 1'b1;
                winner  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS arbiter: grants one requester at a time and sequences
// grant -> setup -> DEMAND -> XFER/timeout/abandon -> release.
module ebus_arbiter
    import ebus_arbiter_pkg::*;
#(
    parameter int NREQ    = EBUS_NREQ,
    parameter int SETUP   = 2,
    parameter int TIMEOUT = 64,
    parameter int RR      = 1
) (
    input  logic           clk,
    input  logic           reset,
    ebus_arbiter_if.master bus
);

    localparam int IDX_W = clog2_min1(NREQ);
    localparam int CNT_W = clog2_min1(max_int(SETUP, TIMEOUT));

    if (SETUP < 1 || TIMEOUT < 2) begin : g_param_check
        $error("ebus_arbiter: SETUP must be >= 1 and TIMEOUT >= 2");
    end

    ebus_arb_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:NREQ-1]  grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             demand_q, demand_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    ebus_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .rr_mode (RR != 0),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        demand_d    = demand_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    grant_idx_d       = pick_idx;
                    cnt_d             = '0;
                    state_d           = ST_SETUP;
                end
            end
            // Abandon by the grantee takes priority over every other exit.
            ST_SETUP: begin
                if (!bus.req[grant_idx_q]) begin
                    demand_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_W'(SETUP - 1)) begin
                    demand_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DEMAND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEMAND: begin
                if (!bus.req[grant_idx_q]) begin
                    demand_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (bus.xfer) begin
                    demand_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    demand_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
                if (RR != 0) begin
                    rr_ptr_d = (grant_idx_q == IDX_W'(NREQ - 1)) ? '0
                                                                  : grant_idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            demand_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            demand_q    <= demand_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grantIdx    = grant_idx_q;
    assign bus.busy        = busy_q;
    assign bus.ebusDemand  = demand_q;
    assign bus.xferDone    = done_q;
    assign bus.xferTimeout = timeout_q;

endmodule

// File: tb/tb_ebus_arbiter.sv
// Bench for ebus_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream and are checked against a timestamp-based transfer model.
module tb_ebus_arbiter;
    import ebus_arbiter_pkg::*;

    localparam int NREQ    = 11;
    localparam int SETUP   = 2;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(NREQ);

    typedef logic [0:NREQ-1] vec_t;

    typedef struct {
        string name;
        logic  rst;
        vec_t  req;
        logic  xfer;
        vec_t  grant;
        int    idx;
        logic  busy;
        logic  dem;
        logic  done;
        logic  tmo;
    } vec_rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic xfer  = 1'b0;
    vec_t req   = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    ebus_arbiter_if #(.NREQ(NREQ)) bus_rr ();
    ebus_arbiter_if #(.NREQ(NREQ)) bus_fx ();

    assign bus_rr.req  = req;
    assign bus_rr.xfer = xfer;
    assign bus_fx.req  = req;
    assign bus_fx.xfer = xfer;

    ebus_arbiter #(.NREQ(NREQ), .SETUP(SETUP), .TIMEOUT(TIMEOUT), .RR(1)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr)
    );

    ebus_arbiter #(.NREQ(NREQ), .SETUP(SETUP), .TIMEOUT(TIMEOUT), .RR(0)) dut_fx (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fx)
    );

    // Reference model per instance (0 = round-robin, 1 = fixed): a transfer is
    // described by its owner, the edge it was granted on and the edge it ended on.
    int m_owner [2];
    int m_gedge [2];
    int m_eedge [2];
    int m_kind  [2];  // 0 abandon, 1 acknowledged, 2 timed out
    int m_last  [2];
    int m_ptr   [2];

    function automatic vec_t oh(input int i);
        vec_t v;
        v = '0;
        v[IW'(i)] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input vec_t r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[IW'((start + k) % NREQ)]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        int w;
        int age;
        if (reset) begin
            m_owner[m] = -1; m_eedge[m] = -1; m_kind[m] = 0;
            m_last[m]  = 0;  m_ptr[m]   = 0;  m_gedge[m] = 0;
        end else if (m_owner[m] < 0) begin
            w = pick(req, (m == 0) ? m_ptr[m] : 0);
            if (w >= 0) begin
                m_owner[m] = w; m_gedge[m] = cyc; m_last[m] = w; m_kind[m] = 0;
            end
        end else if (m_eedge[m] >= 0) begin
            if (m == 0) m_ptr[m] = (m_owner[m] + 1) % NREQ;
            m_owner[m] = -1; m_eedge[m] = -1; m_kind[m] = 0;
        end else begin
            age = cyc - m_gedge[m];
            if (!req[IW'(m_owner[m])]) begin
                m_eedge[m] = cyc; m_kind[m] = 0;
            end else if (age > SETUP) begin
                if (xfer) begin
                    m_eedge[m] = cyc; m_kind[m] = 1;
                end else if (age - SETUP == TIMEOUT) begin
                    m_eedge[m] = cyc; m_kind[m] = 2;
                end
            end
        end
    endtask

    task automatic get_out(input int m, output vec_t g, output logic [IW-1:0] ix,
                           output logic b, output logic d, output logic dn, output logic to);
        if (m == 0) begin
            g = bus_rr.grant; ix = bus_rr.grantIdx; b = bus_rr.busy;
            d = bus_rr.ebusDemand; dn = bus_rr.xferDone; to = bus_rr.xferTimeout;
        end else begin
            g = bus_fx.grant; ix = bus_fx.grantIdx; b = bus_fx.busy;
            d = bus_fx.ebusDemand; dn = bus_fx.xferDone; to = bus_fx.xferTimeout;
        end
    endtask

    task automatic cmp_exp(input string name, input int m, input vec_t eg, input int eix,
                           input logic eb, input logic ed, input logic edn, input logic eto);
        vec_t g;
        logic [IW-1:0] ix;
        logic b, d, dn, to;
        get_out(m, g, ix, b, d, dn, to);
        checks++;
        if ({g, ix, b, d, dn, to} !== {eg, IW'(eix), eb, ed, edn, eto}) begin
            errors++;
            $display("FAIL %s dut%0d edge%0d: got grant=%b idx=%0d busy=%b dem=%b done=%b tmo=%b, want grant=%b idx=%0d busy=%b dem=%b done=%b tmo=%b",
                     name, m, cyc, g, ix, b, d, dn, to, eg, eix, eb, ed, edn, eto);
        end
    endtask

    task automatic cmp_model(input int m);
        logic on;
        on = (m_owner[m] >= 0);
        cmp_exp("model", m, on ? oh(m_owner[m]) : vec_t'('0), m_last[m], on,
                on && m_eedge[m] < 0 && (cyc - m_gedge[m]) >= SETUP,
                m_eedge[m] == cyc && m_kind[m] == 1,
                m_eedge[m] == cyc && m_kind[m] == 2);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        cmp_model(0);
        cmp_model(1);
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; xfer = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_demand(input string name);
        int n;
        n = 0;
        while (bus_rr.ebusDemand !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        expect_int({name, "_demand_seen"}, int'(bus_rr.ebusDemand === 1'b1), 1);
    endtask

    function automatic vec_rec_t mk(input string nm, input logic r, input vec_t rq, input logic x,
                                    input vec_t g, input int ix, input logic b, input logic d,
                                    input logic dn, input logic to);
        vec_rec_t v;
        v.name = nm; v.rst = r; v.req = rq; v.xfer = x; v.grant = g; v.idx = ix;
        v.busy = b; v.dem = d; v.done = dn; v.tmo = to;
        return v;
    endfunction

    initial begin
        vec_rec_t tbl[$];
        int q_rr[$];
        int q_fx[$];
        int n;
        int phase;
        logic saw_done;
        logic pb_rr, pb_fx;
        int t3, t4, t5a, t5b, t6, t7;

        t3 = int'(EBUS_CTL); t4 = int'(EBUS_CRA); t5a = int'(EBUS_CON);
        t5b = int'(EBUS_EDP); t6 = int'(EBUS_IR); t7 = int'(EBUS_PI);

        // Reset with every request up, one grant, abandon, then a full acked transfer.
        tbl.push_back(mk("rst0",      1, '1,      0, '0,      0,  0, 0, 0, 0));
        tbl.push_back(mk("rst1",      1, '1,      0, '0,      0,  0, 0, 0, 0));
        tbl.push_back(mk("grant0",    0, '1,      0, oh(0),   0,  1, 0, 0, 0));
        tbl.push_back(mk("abandon0",  0, '0,      0, oh(0),   0,  1, 0, 0, 0));
        tbl.push_back(mk("idle0",     0, '0,      0, '0,      0,  0, 0, 0, 0));
        tbl.push_back(mk("grant3",    0, oh(t3),  0, oh(t3),  t3, 1, 0, 0, 0));
        tbl.push_back(mk("setup3",    0, oh(t3),  0, oh(t3),  t3, 1, 0, 0, 0));
        tbl.push_back(mk("demand3",   0, oh(t3),  0, oh(t3),  t3, 1, 1, 0, 0));
        tbl.push_back(mk("done3",     0, oh(t3),  1, oh(t3),  t3, 1, 0, 1, 0));
        tbl.push_back(mk("release3",  0, oh(t3),  0, '0,      t3, 0, 0, 0, 0));
        tbl.push_back(mk("regrant3",  0, oh(t3),  0, oh(t3),  t3, 1, 0, 0, 0));
        tbl.push_back(mk("drop3",     0, '0,      0, oh(t3),  t3, 1, 0, 0, 0));
        tbl.push_back(mk("idle3",     0, '0,      0, '0,      t3, 0, 0, 0, 0));
        tbl.push_back(mk("xfer_idle", 0, '0,      1, '0,      t3, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; req = tbl[i].req; xfer = tbl[i].xfer;
            step();
            for (int m = 0; m < 2; m++)
                cmp_exp(tbl[i].name, m, tbl[i].grant, tbl[i].idx, tbl[i].busy,
                        tbl[i].dem, tbl[i].done, tbl[i].tmo);
        end

        // Timeout: no XFER, pulse exactly TIMEOUT edges after DEMAND rises.
        do_reset();
        req = oh(t4);
        step();
        wait_demand("timeout");
        n = 0; saw_done = 1'b0;
        while (bus_rr.xferTimeout !== 1'b1 && n < 100) begin
            step();
            n++;
            if (bus_rr.xferDone === 1'b1) saw_done = 1'b1;
        end
        expect_int("timeout_latency", n, TIMEOUT);
        expect_int("timeout_no_done", int'(saw_done), 0);
        step();
        expect_int("timeout_idle_busy", int'(bus_rr.busy), 0);
        expect_int("timeout_idle_grant", int'(bus_rr.grant == '0), 1);
        req = '0;
        step();

        // Two steady requesters, every transfer acked.
        do_reset();
        req = oh(0) | oh(2); xfer = 1'b1;
        pb_rr = 1'b0; pb_fx = 1'b0;
        for (int k = 0; k < 60 && q_rr.size() < 4; k++) begin
            step();
            if (bus_rr.busy && !pb_rr) q_rr.push_back(int'(bus_rr.grantIdx));
            if (bus_fx.busy && !pb_fx) q_fx.push_back(int'(bus_fx.grantIdx));
            pb_rr = bus_rr.busy; pb_fx = bus_fx.busy;
        end
        expect_int("rr_grant_count", q_rr.size(), 4);
        foreach (q_rr[i]) expect_int($sformatf("rr_seq%0d", i), q_rr[i], (i % 2 == 1) ? 2 : 0);
        expect_int("fx_grant_count", int'(q_fx.size() >= 3), 1);
        foreach (q_fx[i]) expect_int($sformatf("fx_seq%0d", i), q_fx[i], 0);
        xfer = 1'b0; req = '0;
        step(); step(); step();

        // Grantee drops its request mid-DEMAND.
        do_reset();
        req = oh(t5a) | oh(t5b);
        step();
        wait_demand("abandon");
        step();
        req = oh(t5b);
        step();
        for (int m = 0; m < 2; m++) cmp_exp("abandon_demand", m, oh(t5a), t5a, 1, 0, 0, 0);
        step();
        for (int m = 0; m < 2; m++) cmp_exp("abandon_idle", m, '0, t5a, 0, 0, 0, 0);
        step();
        for (int m = 0; m < 2; m++) cmp_exp("abandon_next", m, oh(t5b), t5b, 1, 0, 0, 0);
        req = '0;
        step(); step();

        // XFER on the terminal timeout edge: acknowledgement wins.
        do_reset();
        req = oh(t6);
        step();
        wait_demand("terminal");
        for (int k = 0; k < TIMEOUT - 1; k++) step();
        xfer = 1'b1;
        step();
        cmp_exp("terminal_xfer", 0, oh(t6), t6, 1, 0, 1, 0);
        xfer = 1'b0; req = '0;
        step(); step();

        // Reset during DEMAND.
        do_reset();
        req = oh(t7);
        step();
        wait_demand("reset_mid");
        reset = 1'b1;
        step();
        for (int m = 0; m < 2; m++) cmp_exp("reset_mid", m, '0, 0, 0, 0, 0, 0);
        reset = 1'b0; req = '0;
        step();

        // Random traffic; every fourth window holds XFER low so transfers time out.
        for (int i = 0; i < 3000; i++) begin
            phase = (i / 250) % 4;
            reset = ($urandom_range(0, 599) == 0);
            if (phase == 3) begin
                if ($urandom_range(0, 99) == 0) req = vec_t'(NREQ'($urandom & $urandom));
                xfer = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) req = vec_t'(NREQ'($urandom & $urandom));
                xfer = ($urandom_range(0, 2) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
